// File: rtl/read_memory_arbiter.sv
// Shares one read-only memory slave between NUMBER_OF_REQUESTERS clients, one full handshake at a time.
// Build option: define READ_MEMORY_ARBITER_FIXED_PRIORITY_EN for lowest-index-wins instead of round-robin.
module read_memory_arbiter #(
    parameter  int NUMBER_OF_REQUESTERS = 4,
    parameter  int ADDRESS_WIDTH        = 32,
    parameter  int DATA_WIDTH           = 32,
    localparam int GRANT_WIDTH          = $clog2(NUMBER_OF_REQUESTERS)
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic [NUMBER_OF_REQUESTERS*ADDRESS_WIDTH-1:0] requestAddress,
    input  logic [NUMBER_OF_REQUESTERS-1:0]               requestReadEnabled,
    output logic [DATA_WIDTH-1:0]                         requestDataIn,
    output logic [NUMBER_OF_REQUESTERS-1:0]               requestFunctionComplete,
    output logic [ADDRESS_WIDTH-1:0]                      memoryAddress,
    output logic                                          memoryReadEnabled,
    input  logic [DATA_WIDTH-1:0]                         memoryDataIn,
    input  logic                                          memoryFunctionComplete,
    output logic                                          busy
);

    // Handshake: a client raises readEnabled and holds it (and its address) until it sees its
    // complete bit; it then drops readEnabled, and the grant is released once both the request
    // and the slave's complete are low in the same cycle. Dropping the request early aborts.

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [GRANT_WIDTH-1:0]   r_grant;
    logic [GRANT_WIDTH-1:0]   w_grant_next;
    logic [GRANT_WIDTH-1:0]   w_search_base;
    logic [GRANT_WIDTH-1:0]   w_pick;
    logic                     w_release;
    logic [ADDRESS_WIDTH-1:0] w_addr [NUMBER_OF_REQUESTERS];

    // First set request bit at or after base, wrapping modulo the client count.
    function automatic logic [GRANT_WIDTH-1:0] f_pick(
        input logic [NUMBER_OF_REQUESTERS-1:0] req,
        input logic [GRANT_WIDTH-1:0]          base
    );
        logic [GRANT_WIDTH-1:0] result;
        logic [GRANT_WIDTH-1:0] sel;
        int                     idx;
        result = base;
        for (int j = NUMBER_OF_REQUESTERS - 1; j >= 0; j--) begin
            idx = (int'(base) + j) % NUMBER_OF_REQUESTERS;
            sel = GRANT_WIDTH'(idx);
            if (req[sel]) begin
                result = sel;
            end
        end
        return result;
    endfunction

    always_comb begin
        for (int i = 0; i < NUMBER_OF_REQUESTERS; i++) begin
            w_addr[i] = requestAddress[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        end
    end

    assign w_pick    = f_pick(requestReadEnabled, w_search_base);
    assign w_release = (r_state == BUSY) && !requestReadEnabled[r_grant] && !memoryFunctionComplete;

`ifdef READ_MEMORY_ARBITER_FIXED_PRIORITY_EN
    assign w_search_base = '0;
`else
    logic [GRANT_WIDTH-1:0] r_pointer;
    logic [GRANT_WIDTH-1:0] w_grant_inc;

    assign w_grant_inc = (r_grant == GRANT_WIDTH'(NUMBER_OF_REQUESTERS - 1)) ?
                         '0 : r_grant + GRANT_WIDTH'(1);

    // The client just served becomes lowest priority for the next arbitration.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pointer <= '0;
        end else if (w_release) begin
            r_pointer <= w_grant_inc;
        end
    end

    assign w_search_base = r_pointer;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_grant <= '0;
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        case (r_state)
            IDLE: begin
                if (|requestReadEnabled) begin
                    w_state_next = BUSY;
                    w_grant_next = w_pick;
                end
            end
            BUSY: begin
                if (w_release) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        memoryAddress           = '0;
        memoryReadEnabled       = 1'b0;
        requestFunctionComplete = '0;
        if (r_state == BUSY) begin
            memoryAddress                    = w_addr[r_grant];
            memoryReadEnabled                = requestReadEnabled[r_grant];
            requestFunctionComplete[r_grant] = memoryFunctionComplete;
        end
    end

    assign requestDataIn = memoryDataIn;
    assign busy          = (r_state == BUSY);

endmodule
